// File: rtl/mul_shift_add32_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
//   WIDTH   : operand width (the ripple-carry adder is 32 bits wide)
//   PROD_W  : product width, 2*WIDTH
//   state_t : control states of the multiplier FSM
package mul_shift_add32_pkg;

  localparam int WIDTH  = 32;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add32_if.sv
// Operand/result handshake bundle for mul_shift_add32.
//   in_valid/in_ready   : operand handshake (op1 multiplicand, op2 multiplier)
//   out_valid/out_ready : product handshake
//   product             : 64-bit unsigned result
//   busy                : multiplier is running or holding a result
// master = operand producer / result consumer, slave = the multiplier.
interface mul_shift_add32_if;
  import mul_shift_add32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mul_shift_add32_adder.sv
// AdderRC32bit: 32-bit ripple-carry adder used as the add stage of the
// multiplier.
//   op1, op2 : addends
//   cin      : carry in
//   sum      : op1 + op2 + cin, low 32 bits
//   cout     : carry out of bit 31
module AdderRC32bit (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fa
      // Carry kept per bit slice rather than in one shared vector so the
      // chain is not seen as a self-dependent signal.
      logic c_in;
      logic c_out;
      if (gi == 0) begin : g_first
        assign c_in = cin;
      end else begin : g_next
        assign c_in = g_fa[gi-1].c_out;
      end
      assign sum[gi] = op1[gi] ^ op2[gi] ^ c_in;
      assign c_out   = (op1[gi] & op2[gi]) | (c_in & (op1[gi] ^ op2[gi]));
    end
  endgenerate

  assign cout = g_fa[31].c_out;

endmodule

// File: rtl/mul_shift_add32.sv
// mul_shift_add32: sequential 32x32 -> 64-bit unsigned radix-2
// shift-and-add multiplier built around a single reused ripple-carry adder.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of mul_shift_add32_if (operands, product, busy)
// One operand pair is accepted in IDLE, 32 iterations run (one per cycle),
// then the product is held in DONE until the consumer takes it.
module mul_shift_add32
  import mul_shift_add32_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  mul_shift_add32_if.slave bus
);

  if (WIDTH != 32) begin : g_width_check
    $fatal(1, "mul_shift_add32: WIDTH must be 32 to match AdderRC32bit");
  end

  state_t            state_reg;
  logic [WIDTH-1:0]  mcand_reg;
  logic [WIDTH-1:0]  acc_hi_reg;
  logic [WIDTH-1:0]  acc_lo_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PROD_W-1:0] product_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              busy_reg;

  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic [WIDTH-1:0]  acc_hi_next;
  logic [WIDTH-1:0]  acc_lo_next;

  AdderRC32bit u_add (
    .op1  (acc_hi_reg),
    .op2  (mcand_reg),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // One iteration: optionally add the multiplicand into the high half, then
  // shift the whole 65-bit {carry, acc_hi, acc_lo} right by one. The adder
  // carry lands in bit 63, which matters whenever op1 >= 2^31.
  always_comb begin
    acc_hi_next = {1'b0, acc_hi_reg[WIDTH-1:1]};
    acc_lo_next = {acc_hi_reg[0], acc_lo_reg[WIDTH-1:1]};
    if (acc_lo_reg[0]) begin
      acc_hi_next = {cout, sum[WIDTH-1:1]};
      acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      mcand_reg     <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      count_reg     <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            mcand_reg    <= bus.op1;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= bus.op2;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == CNT_W'(WIDTH - 1)) begin
            // Product gets its own register so it survives the next load
            // of the accumulator.
            product_reg   <= {acc_hi_next, acc_lo_next};
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_mul_shift_add32.sv
// Scoreboard bench for mul_shift_add32: directed operand pairs with
// hand-computed products are queued at acceptance; a monitor pops and
// compares on every product handoff and checks latency and hold behaviour.
module tb_mul_shift_add32;

  logic clk;
  logic rst;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_count = 0;
  int rx_count = 0;
  int accept_cyc = 0;

  logic [63:0] exp_q[$];

  mul_shift_add32_if bus();

  mul_shift_add32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Issue one operand pair; queue the expected product unless the
  // transaction is going to be aborted by reset.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input bit push);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      timeout_fail("send_wait_in_ready");
      return;
    end
    bus.op1      = a;
    bus.op2      = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    accept_cyc   = cyc;
    if (push) begin
      exp_q.push_back(e);
      tx_count++;
    end
    check("in_ready_low_after_accept", {63'd0, bus.in_ready}, 64'd0);
    $display("send %0d: op1=%h op2=%h expect=%h", tx_count, a, b, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!(exp_q.size() == 0 && bus.in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(exp_q.size() == 0 && bus.in_ready)) timeout_fail("drain");
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) timeout_fail("wait_out_valid");
  endtask

  // Monitor / scoreboard
  initial begin
    logic        ov_prev;
    logic        ir_pending;
    logic [63:0] held;
    logic [63:0] e;
    ov_prev    = 1'b0;
    ir_pending = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev    = 1'b0;
        ir_pending = 1'b0;
      end else begin
        if (ir_pending) begin
          check("in_ready_after_handoff", {63'd0, bus.in_ready}, 64'd1);
          ir_pending = 1'b0;
        end
        if (bus.out_valid && !ov_prev) begin
          check("latency", 64'(cyc - accept_cyc), 64'd32);
          held = bus.product;
        end else if (bus.out_valid) begin
          check("product_hold", bus.product, held);
        end
        if (bus.out_valid) begin
          check("in_ready_low_done", {63'd0, bus.in_ready}, 64'd0);
        end
        if (bus.out_valid && bus.out_ready) begin
          rx_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_product: got %h, expected none", bus.product);
          end else begin
            e = exp_q.pop_front();
            check("product", bus.product, e);
            $display("recv %0d: product=%h expect=%h", rx_count, bus.product, e);
          end
          ir_pending = 1'b1;
        end
        ov_prev = bus.out_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.out_ready = 1'b1;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_busy",      {63'd0, bus.busy},      64'd0);
    check("reset_product",   bus.product,            64'd0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;

    // Basic and carry/max cases
    send(32'd3, 32'd5, 64'h000000000000000F, 1'b1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);
    send(32'h80000000, 32'd2, 64'h0000000100000000, 1'b1);
    drain();

    // Backpressure: five cycles of out_ready=0 while the product is held
    bus.out_ready = 1'b0;
    send(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, 1'b1);
    wait_out_valid();
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Operand changes during RUN must be ignored
    send(32'd7, 32'd9, 64'd63, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op1      = 32'hFFFFFFFF;
    bus.op2      = 32'hFFFFFFFF;
    check("busy_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("busy_high_run",     {63'd0, bus.busy},     64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("busy_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-RUN: outputs drop without a clock edge, partial discarded
    send(32'd100, 32'd100, 64'd10000, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("abort_busy",      {63'd0, bus.busy},      64'd0);
    check("abort_product",   bus.product,            64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    send(32'd2, 32'd3, 64'd6, 1'b1);
    drain();

    // Zero multiplicand still runs the full latency
    send(32'd0, 32'hDEADBEEF, 64'd0, 1'b1);
    drain();

    repeat (40) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("rx_count",    64'(rx_count),     64'(tx_count));
    check("final_idle",  {63'd0, bus.in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
